// File: rtl/commit_unit.sv
// In-order retirement stage: turns ROB commit records into RF writeback, store release,
// mispredict flush/redirect and halt. Optional COMMIT_CNT_EN adds a 64-bit retired counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | accepting commit records, one per cycle
// FLUSH | clear_branch_out held high while flush counter runs down
// HALT  | halt retired; terminal until reset, no strobes
module commit_unit #(
  parameter int ID_W         = 6,
  parameter int ROB_W        = 4,
  parameter int LSB_W        = 4,
  parameter int STORE_ID_LO  = 13,
  parameter int STORE_ID_HI  = 15,
  parameter int HALT_ID      = 37,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              commit_en_in,
  input  logic [ID_W-1:0]   instr_id_in,
  input  logic [4:0]        rd_in,
  input  logic [ROB_W-1:0]  rob_pos_in,
  input  logic [LSB_W-1:0]  lsb_pos_in,
  input  logic [31:0]       res_in,
  input  logic              jump_en_in,
  input  logic [31:0]       jump_a_in,
  output logic              rf_wr_en_out,
  output logic [4:0]        rf_rd_out,
  output logic [31:0]       rf_data_out,
  output logic [ROB_W-1:0]  rf_rob_pos_out,
  output logic              lsb_commit_en_out,
  output logic [LSB_W-1:0]  lsb_commit_pos_out,
  output logic              clear_branch_out,
  output logic              pc_redirect_en_out,
  output logic [31:0]       pc_redirect_a_out,
  output logic              halted_out
`ifdef COMMIT_CNT_EN
  ,
  output logic [63:0]       retired_cnt_out
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  localparam logic [ID_W-1:0] STORE_LO  = ID_W'(STORE_ID_LO);
  localparam logic [ID_W-1:0] STORE_HI  = ID_W'(STORE_ID_HI);
  localparam logic [ID_W-1:0] HALT_V    = ID_W'(HALT_ID);
  localparam logic [3:0]      FLUSH_TC  = 4'(FLUSH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         flush_cnt_q, flush_cnt_d;
  logic               accept, is_store, is_halt;
  logic               rf_wr_en_d, lsb_commit_en_d, clear_branch_d, pc_redirect_en_d, halted_d;
  logic [4:0]         rf_rd_d;
  logic [31:0]        rf_data_d, pc_redirect_a_d;
  logic [ROB_W-1:0]   rf_rob_pos_d;
  logic [LSB_W-1:0]   lsb_commit_pos_d;

  assign is_store = (instr_id_in >= STORE_LO) && (instr_id_in <= STORE_HI);
  assign is_halt  = (instr_id_in == HALT_V);
  assign accept   = commit_en_in && (state_q == RUN);

  // Next values assume rdy_in; the register block applies them only on rdy cycles.
  always_comb begin
    state_d            = state_q;
    flush_cnt_d        = flush_cnt_q;
    rf_wr_en_d         = 1'b0;
    lsb_commit_en_d    = 1'b0;
    pc_redirect_en_d   = 1'b0;
    clear_branch_d     = clear_branch_out;
    halted_d           = halted_out;
    rf_rd_d            = rf_rd_out;
    rf_data_d          = rf_data_out;
    rf_rob_pos_d       = rf_rob_pos_out;
    lsb_commit_pos_d   = lsb_commit_pos_out;
    pc_redirect_a_d    = pc_redirect_a_out;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (rd_in != 5'd0 && !is_store) begin
            rf_wr_en_d   = 1'b1;
            rf_rd_d      = rd_in;
            rf_data_d    = res_in;
            rf_rob_pos_d = rob_pos_in;
          end
          if (is_store) begin
            lsb_commit_en_d  = 1'b1;
            lsb_commit_pos_d = lsb_pos_in;
          end
          if (is_halt) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (jump_en_in) begin
            pc_redirect_en_d = 1'b1;
            pc_redirect_a_d  = jump_a_in;
            clear_branch_d   = 1'b1;
            flush_cnt_d      = FLUSH_TC;
            state_d          = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          clear_branch_d = 1'b0;
          state_d        = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q            <= RUN;
      flush_cnt_q        <= 4'd0;
      rf_wr_en_out       <= 1'b0;
      rf_rd_out          <= 5'd0;
      rf_data_out        <= 32'd0;
      rf_rob_pos_out     <= '0;
      lsb_commit_en_out  <= 1'b0;
      lsb_commit_pos_out <= '0;
      clear_branch_out   <= 1'b0;
      pc_redirect_en_out <= 1'b0;
      pc_redirect_a_out  <= 32'd0;
      halted_out         <= 1'b0;
    end else if (rdy_in) begin
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      rf_wr_en_out       <= rf_wr_en_d;
      rf_rd_out          <= rf_rd_d;
      rf_data_out        <= rf_data_d;
      rf_rob_pos_out     <= rf_rob_pos_d;
      lsb_commit_en_out  <= lsb_commit_en_d;
      lsb_commit_pos_out <= lsb_commit_pos_d;
      clear_branch_out   <= clear_branch_d;
      pc_redirect_en_out <= pc_redirect_en_d;
      pc_redirect_a_out  <= pc_redirect_a_d;
      halted_out         <= halted_d;
    end
  end

`ifdef COMMIT_CNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      retired_cnt_out <= 64'd0;
    else if (rdy_in && accept)
      retired_cnt_out <= retired_cnt_out + 64'd1;
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with hand-computed expectations.
// Also covers the retired counter when built with COMMIT_CNT_EN.
module tb_commit_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        commit_en_in = 1'b0;
  logic [5:0]  instr_id_in = '0;
  logic [4:0]  rd_in = '0;
  logic [3:0]  rob_pos_in = '0;
  logic [3:0]  lsb_pos_in = '0;
  logic [31:0] res_in = '0;
  logic        jump_en_in = 1'b0;
  logic [31:0] jump_a_in = '0;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_data_out;
  logic [3:0]  rf_rob_pos_out;
  logic        lsb_commit_en_out;
  logic [3:0]  lsb_commit_pos_out;
  logic        clear_branch_out;
  logic        pc_redirect_en_out;
  logic [31:0] pc_redirect_a_out;
  logic        halted_out;
`ifdef COMMIT_CNT_EN
  logic [63:0] retired_cnt_out;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt;
  int clr_cnt;

  always #5 clk_in = ~clk_in;

  commit_unit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .commit_en_in(commit_en_in),
    .instr_id_in(instr_id_in), .rd_in(rd_in), .rob_pos_in(rob_pos_in), .lsb_pos_in(lsb_pos_in),
    .res_in(res_in), .jump_en_in(jump_en_in), .jump_a_in(jump_a_in),
    .rf_wr_en_out(rf_wr_en_out), .rf_rd_out(rf_rd_out), .rf_data_out(rf_data_out),
    .rf_rob_pos_out(rf_rob_pos_out), .lsb_commit_en_out(lsb_commit_en_out),
    .lsb_commit_pos_out(lsb_commit_pos_out), .clear_branch_out(clear_branch_out),
    .pc_redirect_en_out(pc_redirect_en_out), .pc_redirect_a_out(pc_redirect_a_out),
    .halted_out(halted_out)
`ifdef COMMIT_CNT_EN
    , .retired_cnt_out(retired_cnt_out)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic en, input logic [5:0] id, input logic [4:0] rd,
                       input logic [3:0] rob, input logic [3:0] lsb, input logic [31:0] res,
                       input logic jen, input logic [31:0] ja);
    commit_en_in = en; instr_id_in = id; rd_in = rd; rob_pos_in = rob;
    lsb_pos_in = lsb; res_in = res; jump_en_in = jen; jump_a_in = ja;
  endtask

  initial begin
    #1 rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_val("rst_rf_wr_en", rf_wr_en_out, 0);
    check_val("rst_rf_data", rf_data_out, 0);
    check_val("rst_clear", clear_branch_out, 0);
    check_val("rst_halted", halted_out, 0);
    check_val("rst_redir_a", pc_redirect_a_out, 0);
    @(negedge clk_in) rst_n_in = 1'b1;
    tick();

    // plain writeback
    drive(1, 6'd0, 5'd5, 4'd3, 4'd0, 32'h1234, 0, 0);
    tick();
    check_val("wb_en", rf_wr_en_out, 1);
    check_val("wb_rd", rf_rd_out, 5);
    check_val("wb_data", rf_data_out, 32'h1234);
    check_val("wb_rob", rf_rob_pos_out, 3);
    check_val("wb_lsb_en", lsb_commit_en_out, 0);
    check_val("wb_redir_en", pc_redirect_en_out, 0);
    check_val("wb_clear", clear_branch_out, 0);

    // store: release, no writeback despite rd!=0
    drive(1, 6'd15, 5'd7, 4'd4, 4'd9, 32'hDEAD, 0, 0);
    tick();
    check_val("st_lsb_en", lsb_commit_en_out, 1);
    check_val("st_lsb_pos", lsb_commit_pos_out, 9);
    check_val("st_rf_wr_en", rf_wr_en_out, 0);
    check_val("st_rf_data_hold", rf_data_out, 32'h1234);

    // JAL: link write + redirect + flush
    drive(1, 6'd2, 5'd1, 4'd5, 4'd0, 32'h104, 1, 32'h200);
    tick();
    check_val("jal_wr_en", rf_wr_en_out, 1);
    check_val("jal_rd", rf_rd_out, 1);
    check_val("jal_data", rf_data_out, 32'h104);
    check_val("jal_redir_en", pc_redirect_en_out, 1);
    check_val("jal_redir_a", pc_redirect_a_out, 32'h200);
    check_val("jal_clear0", clear_branch_out, 1);
    check_val("jal_lsb_en", lsb_commit_en_out, 0);
    drive(1, 6'd0, 5'd9, 4'd6, 4'd0, 32'h55, 0, 0);
    tick();
    check_val("fl_clear1", clear_branch_out, 1);
    check_val("fl_redir_pulse", pc_redirect_en_out, 0);
    check_val("fl_drop_wr", rf_wr_en_out, 0);
    tick();
    check_val("fl_clear_fall", clear_branch_out, 0);
    check_val("fl_drop_wr2", rf_wr_en_out, 0);
    drive(0, 6'd0, 5'd0, 4'd0, 4'd0, 32'h0, 0, 0);
    tick();
    check_val("fl_drop_data", rf_data_out, 32'h104);

    // rdy low with a held record: exactly one write
    drive(1, 6'd0, 5'd10, 4'd2, 4'd0, 32'hAAAA, 0, 0);
    rdy_in = 1'b0;
    wr_cnt = 0;
    repeat (3) begin
      tick();
      if (rf_wr_en_out) wr_cnt++;
    end
    rdy_in = 1'b1;
    tick();
    if (rf_wr_en_out) wr_cnt++;
    check_val("rdy_data", rf_data_out, 32'hAAAA);
    drive(0, 6'd0, 5'd0, 4'd0, 4'd0, 32'h0, 0, 0);
    tick();
    if (rf_wr_en_out) wr_cnt++;
    check_val("rdy_one_write", wr_cnt, 1);

    // rdy low mid-FLUSH stretches clear_branch_out by 3 cycles
    drive(1, 6'd3, 5'd0, 4'd1, 4'd0, 32'h0, 1, 32'h300);
    clr_cnt = 0;
    tick();
    if (clear_branch_out) clr_cnt++;
    check_val("st_redir_a", pc_redirect_a_out, 32'h300);
    drive(0, 6'd0, 5'd0, 4'd0, 4'd0, 32'h0, 0, 0);
    rdy_in = 1'b0;
    repeat (3) begin
      tick();
      if (clear_branch_out) clr_cnt++;
    end
    rdy_in = 1'b1;
    repeat (6) begin
      tick();
      if (clear_branch_out) clr_cnt++;
    end
    check_val("stretch_clear_len", clr_cnt, 5);

    // halt beats jump
    drive(1, 6'd37, 5'd0, 4'd0, 4'd0, 32'h0, 1, 32'h400);
    tick();
    check_val("halt_flag", halted_out, 1);
    check_val("halt_no_redir", pc_redirect_en_out, 0);
    check_val("halt_no_clear", clear_branch_out, 0);
    check_val("halt_redir_a_hold", pc_redirect_a_out, 32'h300);
    drive(1, 6'd0, 5'd4, 4'd0, 4'd0, 32'h77, 0, 0);
    tick();
    check_val("halt_no_wr", rf_wr_en_out, 0);
    tick();
    check_val("halt_sticky", halted_out, 1);
    check_val("halt_data_hold", rf_data_out, 32'hAAAA);
`ifdef COMMIT_CNT_EN
    check_val("cnt_accepted", retired_cnt_out, 6);
`endif
    drive(0, 6'd0, 5'd0, 4'd0, 4'd0, 32'h0, 0, 0);

    // async reset during FLUSH
    rst_n_in = 1'b0;
    @(negedge clk_in) rst_n_in = 1'b1;
    tick();
    check_val("rst2_halted", halted_out, 0);
    drive(1, 6'd2, 5'd6, 4'd7, 4'd0, 32'h66, 1, 32'h500);
    tick();
    check_val("rst2_clear_pre", clear_branch_out, 1);
    check_val("rst2_wr_pre", rf_wr_en_out, 1);
    drive(0, 6'd0, 5'd0, 4'd0, 4'd0, 32'h0, 0, 0);
    #2 rst_n_in = 1'b0;
    #1;
    check_val("async_clear", clear_branch_out, 0);
    check_val("async_wr_en", rf_wr_en_out, 0);
    check_val("async_redir_en", pc_redirect_en_out, 0);
    @(negedge clk_in) rst_n_in = 1'b1;
    tick();
    drive(1, 6'd0, 5'd8, 4'd1, 4'd0, 32'h88, 0, 0);
    tick();
    check_val("post_rst_wr", rf_wr_en_out, 1);
    check_val("post_rst_data", rf_data_out, 32'h88);
    check_val("post_rst_clear", clear_branch_out, 0);
`ifdef COMMIT_CNT_EN
    check_val("post_rst_cnt", retired_cnt_out, 1);
`endif
    drive(0, 6'd0, 5'd0, 4'd0, 4'd0, 32'h0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage that receives the per-cycle commit record from the reorder buffer and turns it into architectural side effects: register-file writeback, store release to the load/store buffer, branch-mispredict flush with PC redirect, and halt detection. It is the consumer end of the ROB commit interface, and the sole driver of the ROB's `clear_branch_in`. All outputs are registered.

## Interface
- `ID_W`, default 6: instruction-id width
- `ROB_W`, default 4: ROB index width
- `LSB_W`, default 4: LSB index width
- `STORE_ID_LO`, default 13: lowest store id (SB)
- `STORE_ID_HI`, default 15: highest store id (SW)
- `HALT_ID`, default 37: halt instruction id
- `FLUSH_CYCLES`, default 2: cycles `clear_branch_out` stays high; legal range 1..15

Ports:
- `clk_in` in 1: clock
- `rst_n_in` in 1: asynchronous, active-low reset
- `rdy_in` in 1: global enable; low freezes all state
- `commit_en_in` in 1: ROB commit record valid (single-cycle per record)
- `instr_id_in` in ID_W: instruction id
- `rd_in` in 5: destination register; 0 = no writeback
- `rob_pos_in` in ROB_W: ROB slot of the record
- `lsb_pos_in` in LSB_W: LSB slot (stores only)
- `res_in` in 32: result value
- `jump_en_in` in 1: redirect required
- `jump_a_in` in 32: redirect target
- `rf_wr_en_out` out 1: register write strobe
- `rf_rd_out` out 5: register index
- `rf_data_out` out 32: write data
- `rf_rob_pos_out` out ROB_W: tag the register file uses to clear its rename entry if it still matches
- `lsb_commit_en_out` out 1: store release strobe
- `lsb_commit_pos_out` out LSB_W: store slot released
- `clear_branch_out` out 1: flush to ROB, RS, LSB and issue
- `pc_redirect_en_out` out 1: fetch redirect strobe
- `pc_redirect_a_out` out 32: fetch redirect target
- `halted_out` out 1: sticky halt flag

## Operation
- States: RUN, FLUSH, HALT. Reset → RUN.
- A record is accepted when `rdy_in && commit_en_in && state==RUN`. When not accepted, the record is dropped. A dropped record produces no output and no counter change.
- Accepted record actions:
  - `rd_in!=0` → `rf_wr_en_out`=1 with rd, res and rob_pos. This includes JAL/JALR, which write their link register and redirect in the same cycle.
  - `STORE_ID_LO<=instr_id_in<=STORE_ID_HI` → `lsb_commit_en_out`=1, `lsb_commit_pos_out`=`lsb_pos_in`. Stores never write the register file, whatever `rd_in` is.
  - `jump_en_in` → `pc_redirect_en_out`=1, `pc_redirect_a_out`=`jump_a_in`, `clear_branch_out`=1. Load flush counter with `FLUSH_CYCLES-1`. Go to FLUSH.
  - `instr_id_in==HALT_ID` → `halted_out`=1 and go to HALT. Halt takes priority over `jump_en_in`: no flush is issued.
- FLUSH:
  - `clear_branch_out` stays high.
  - The counter decrements each rdy cycle. At 0, return to RUN and `clear_branch_out` falls at the next edge.
  - Records arriving during FLUSH are dropped; they are wrong-path, or are being cleared by the ROB.
- HALT is terminal until reset. All strobes stay 0.
- Strobes (`rf_wr_en_out`, `lsb_commit_en_out`, `pc_redirect_en_out`) are single-cycle pulses and default to 0 every rdy cycle.
- Data outputs hold their last value when the corresponding strobe is 0.
- `rdy_in`=0: no register changes at all. Strobes, state and counters hold. The ROB freezes its record likewise, so it is accepted exactly once.

## Timing
- Latency 1: record sampled at edge N, outputs valid after edge N, for cycle N+1.
- `clear_branch_out` is high for exactly `FLUSH_CYCLES` rdy cycles, starting in the same cycle as `pc_redirect_en_out`.
- Back-to-back records in RUN: one retire per cycle, no bubbles.
- Reset values: all strobes 0, `clear_branch_out` 0, `halted_out` 0, data/index outputs 0, state RUN, flush counter 0.
- Reset asserted mid-FLUSH drops `clear_branch_out` asynchronously.

## Configuration
- `COMMIT_CNT_EN` defined:
  - Adds output `retired_cnt_out` [63:0], reset 0.
  - Increments by 1 per accepted record, including the halt record.
  - Wraps at 2^64.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then record rd=5, res=0x1234, rob_pos=3, id=0 → next cycle `rf_wr_en_out`=1, rd=5, data=0x1234, rob_pos=3. All other strobes 0.
- Record id=15 (SW), rd=7, lsb_pos=9 → `lsb_commit_en_out`=1, pos=9; `rf_wr_en_out`=0.
- JAL record rd=1, res=0x104, jump_en=1, jump_a=0x200, FLUSH_CYCLES=2:
  - Same cycle: rf write x1=0x104, `pc_redirect_en_out` one cycle with 0x200.
  - `clear_branch_out` high 2 cycles.
  - A record presented during FLUSH is dropped.
- `rdy_in` low for 3 cycles while a valid record is held → exactly one rf write after `rdy_in` returns.
  - Repeat mid-FLUSH: `clear_branch_out` is stretched by 3 cycles.
- HALT_ID record with jump_en=1 → `halted_out`=1 with no redirect and no clear. A following record rd=4 produces no write.
  - With `COMMIT_CNT_EN`, the count equals the number of accepted records.
- Assert `rst_n_in` low asynchronously during FLUSH → `clear_branch_out` and all strobes go to 0 immediately. After release, state is RUN.
